// File: rtl/seq_frame_pkg.sv
// Shared types and defaults for the serial frame transmitter.
package seq_frame_pkg;

  // Frame phases: wait for a word, send sync, send payload, send gap zeros.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam int         DATA_W_DEF  = 8;
  localparam int         SYNC_W_DEF  = 5;
  localparam int         GAP_CYC_DEF = 2;
  localparam logic [4:0] SYNC_DEF    = 5'b10001;

  // Largest of three widths; sizes the phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// Parallel-load, MSB-first shift register. Load wins over shift; vacated
// LSBs fill with zero.
module piso_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sh;

  // Hold, load or shift the payload word.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the payload register is plain flops, so it is reset like any
    // other state; a discarded frame never leaks into the next one.
    if (!rst_n) begin
      sh <= '0;
    end else if (load) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      sh <= din;
    end else if (shift) begin
      sh <= sh << 1;
    end
  end

  assign msb = sh[W-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, then payload, both MSB first,
// then a forced-low gap. One bit per clock, all outputs registered.
module seq_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                SYNC_W  = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC    = SYNC_DEF,
  parameter int                GAP_CYC = GAP_CYC_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              dout,
  output logic              busy,
  output logic              frame_done
);

  // Wide enough to hold the largest phase length minus one; reloaded at
  // every phase change so it never wraps.
  localparam int CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_CYC) + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             sh_msb;
  logic             load;
  logic             shift;

  // Sync pattern bit at a given index (index 0 is the last bit sent).
  function automatic logic sync_bit(input logic [CNT_W-1:0] idx);
    logic [SYNC_W-1:0] t;
    t = SYNC >> idx;
    return t[0];
  endfunction

  assign cnt_zero = (cnt == '0);
  assign tx_ready = (state == ST_IDLE);
  assign load     = tx_ready && tx_valid;
  // The shifter advances whenever dout is about to take its MSB, so the
  // next payload bit is already at the MSB on the following edge.
  assign shift    = ((state == ST_SYNC) && cnt_zero) ||
                    ((state == ST_DATA) && !cnt_zero);

  piso_shreg #(.W(DATA_W)) u_shreg (
    .clk   (clk),
    .rst_n (clr_n),
    .load  (load),
    .shift (shift),
    .din   (tx_data),
    .msb   (sh_msb)
  );

  // Frame FSM: outputs are computed from the next phase so they line up
  // with the bit being driven.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          dout       <= 1'b0;
          busy       <= 1'b0;
          frame_done <= 1'b0;
          if (tx_valid) begin
            state <= ST_SYNC;
            cnt   <= CNT_W'(SYNC_W - 1);
            dout  <= SYNC[SYNC_W-1];
            busy  <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (cnt_zero) begin
            state      <= ST_DATA;
            cnt        <= CNT_W'(DATA_W - 1);
            dout       <= sh_msb;
            frame_done <= (DATA_W == 1);
          end else begin
            cnt  <= cnt - CNT_W'(1);
            dout <= sync_bit(cnt - CNT_W'(1));
          end
        end
        ST_DATA: begin
          if (cnt_zero) begin
            state      <= ST_GAP;
            cnt        <= CNT_W'(GAP_CYC - 1);
            dout       <= 1'b0;
            frame_done <= 1'b0;
          end else begin
            cnt        <= cnt - CNT_W'(1);
            dout       <= sh_msb;
            frame_done <= (cnt == CNT_W'(1));
          end
        end
        ST_GAP: begin
          dout <= 1'b0;
          if (cnt_zero) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          dout  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Self-checking bench for seq_frame_tx: frame-level reference model with a
// per-cycle compare, directed literal vectors, a small-parameter instance
// and a loopback sync detector.
module tb_seq_frame_tx;

  localparam int         SW  = 5;
  localparam int         DW  = 8;
  localparam int         GW  = 2;
  localparam logic [4:0] SYN = 5'b10001;

  logic       clk;
  logic       clr_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, dout, busy, frame_done;

  logic [0:0] tx_data2;
  logic       tx_valid2;
  logic       tx_ready2, dout2, busy2, frame_done2;

  int n_chk  = 0;
  int n_fail = 0;

  seq_frame_tx dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done)
  );

  seq_frame_tx #(.DATA_W(1), .SYNC_W(3), .SYNC(3'b101), .GAP_CYC(1)) dut2 (
    .clk        (clk),
    .clr_n      (clr_n),
    .tx_data    (tx_data2),
    .tx_valid   (tx_valid2),
    .tx_ready   (tx_ready2),
    .dout       (dout2),
    .busy       (busy2),
    .frame_done (frame_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one entry per output cycle ----------
  typedef struct {
    bit d;
    bit b;
    bit fd;
    int idx;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  task automatic push_frame(input logic [7:0] w);
    int k;
    k = 0;
    for (int i = 0; i < SW; i++) begin
      q.push_back('{d: SYN[SW-1-i], b: 1'b1, fd: 1'b0, idx: k}); k++;
    end
    for (int i = 0; i < DW; i++) begin
      q.push_back('{d: w[DW-1-i], b: 1'b1, fd: (i == DW-1), idx: k}); k++;
    end
    for (int i = 0; i < GW; i++) begin
      q.push_back('{d: 1'b0, b: 1'b1, fd: 1'b0, idx: k}); k++;
    end
  endtask

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q.delete();
      cur = '{d: 1'b0, b: 1'b0, fd: 1'b0, idx: -1};
    end else begin
      if (q.size() == 0 && !cur.b && tx_valid) push_frame(tx_data);
      if (q.size() > 0) cur = q.pop_front();
      else cur = '{d: 1'b0, b: 1'b0, fd: 1'b0, idx: -1};
    end
  end

  // ---------------- loopback Moore detector for 10001 --------------------
  logic [4:0] hist;
  logic       det_en;
  logic       det;
  int         det_count = 0;

  always @(posedge clk) begin
    if (!det_en) hist <= '0;
    else hist <= {hist[3:0], dout};
  end
  assign det = det_en && (hist == SYN);

  // ---------------- per-cycle compare ------------------------------------
  logic chk_en;

  always @(negedge clk) begin
    if (chk_en) begin
      check("dout", dout, cur.d);
      check("busy", busy, cur.b);
      check("frame_done", frame_done, cur.fd);
      check("tx_ready", tx_ready, !cur.b);
      if (det) begin
        det_count++;
        check("det_timing", cur.idx, SW);
      end
    end
  end

  // ---------------- directed capture --------------------------------------
  logic [63:0] cap_d, cap_fd, cap_b, cap_r;

  task automatic send_capture(input logic [7:0] d, input int n, input int drop_at,
                              input logic [7:0] d_after);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    cap_d = '0; cap_fd = '0; cap_b = '0; cap_r = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_d[n-1-i]  = dout;
      cap_fd[n-1-i] = frame_done;
      cap_b[n-1-i]  = busy;
      cap_r[n-1-i]  = tx_ready;
      if (i == 0) tx_data = d_after;
      if (i == drop_at) tx_valid = 1'b0;
    end
  endtask

  // Payload must not create a 10001 window across sync+payload.
  function automatic bit ok_payload(input logic [7:0] p);
    logic [12:0] s;
    s = {SYN, p};
    for (int j = 1; j <= 8; j++)
      if (s[12-j -: 5] == SYN) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic       fd_any;
    logic [7:0] p;
    clr_n     = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_valid2 = 1'b0;
    tx_data2  = '0;
    det_en    = 1'b0;
    chk_en    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    #1 clr_n = 1'b1;
    chk_en = 1'b1;

    // Idle, no tx_valid for 20 cycles
    repeat (20) @(negedge clk);
    check("idle_tx_ready", tx_ready, 1'b1);
    check("idle_dout", dout, 1'b0);

    // Single frame 8'hA5, tx_data changed after acceptance
    send_capture(8'hA5, 16, 0, 8'h5A);
    check("a5_dout", cap_d, 64'h8D28);
    check("a5_frame_done", cap_fd, 64'h0008);
    check("a5_busy", cap_b, 64'hFFFE);
    check("a5_tx_ready", cap_r, 64'h0001);

    // Back-to-back: FF then 00 with tx_valid held
    send_capture(8'hFF, 32, 16, 8'h00);
    check("b2b_dout", cap_d, 64'h8FF8_8800);
    check("b2b_frame_done", cap_fd, 64'h0008_0008);
    check("b2b_busy", cap_b, 64'hFFFE_FFFE);
    check("b2b_tx_ready", cap_r, 64'h0001_0001);

    // Async reset during payload bit 3 of 8'h3C
    @(negedge clk);
    tx_data  = 8'h3C;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("rst_mid_pre_dout", dout, 1'b1);
    #1 clr_n = 1'b0;
    #1;
    check("rst_mid_dout", dout, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_tx_ready", tx_ready, 1'b1);
    @(negedge clk);
    #1 clr_n = 1'b1;
    fd_any = 1'b0;
    repeat (6) begin
      @(negedge clk);
      fd_any |= frame_done;
    end
    check("rst_mid_no_frame_done", fd_any, 1'b0);
    send_capture(8'h81, 16, 0, 8'h00);
    check("post_rst_dout", cap_d, 64'h8C08);
    check("post_rst_frame_done", cap_fd, 64'h0008);

    // Small-parameter instance: DATA_W=1, SYNC=101, GAP_CYC=1, payload 0
    @(negedge clk);
    tx_data2  = 1'b0;
    tx_valid2 = 1'b1;
    @(posedge clk);
    cap_d = '0; cap_fd = '0; cap_b = '0; cap_r = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cap_d[5-i]  = dout2;
      cap_fd[5-i] = frame_done2;
      cap_b[5-i]  = busy2;
      cap_r[5-i]  = tx_ready2;
      if (i == 0) tx_valid2 = 1'b0;
    end
    check("small_dout", cap_d, 64'b101000);
    check("small_frame_done", cap_fd, 64'b000100);
    check("small_busy", cap_b, 64'b111110);
    check("small_tx_ready", cap_r, 64'b000001);

    // Loopback into the detector: 50 random payloads free of 10001
    @(negedge clk);
    det_en = 1'b1;
    for (int f = 0; f < 50; f++) begin
      do p = 8'($urandom_range(0, 255)); while (!ok_payload(p));
      repeat ($urandom_range(2, 4)) @(negedge clk);
      @(negedge clk);
      tx_data  = p;
      tx_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid = 1'b0;
      repeat (14) @(negedge clk);
    end
    repeat (5) @(negedge clk);
    check("det_count", det_count, 50);
    det_en = 1'b0;
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
